// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Instruction-decode stage for a single-cycle MIPS subset.
//               Holds the 32x32 register file (r0 hard-wired to zero, one
//               write port, two combinational read ports) and decodes the
//               fetched instruction into control strobes, the extended
//               immediate, the destination register number, the branch and
//               jump targets and the next-PC select.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a read of a register that is being
//                       written in the same cycle returns the write data
//                       (write-through). When undefined, the read returns
//                       the pre-write value until the next rising edge.
//
// Ports:
//   clk      in   1   rising-edge clock
//   clrn     in   1   asynchronous active-low reset (clears all registers)
//   inst     in  32   fetched instruction word
//   pc4      in  32   address of inst plus 4
//   we       in   1   write-back enable
//   wn       in   5   write-back register number
//   wd       in  32   write-back data
//   pcsource out  2   next-PC select: 00 pc4, 01 bpc, 10 jpc
//   bpc      out 32   branch target
//   jpc      out 32   jump target
//   qa, qb   out 32   register read data for rs and rt
//   imm      out 32   extended immediate
//   rn       out  5   destination register
//   wreg, m2reg, wmem, aluimm, shift, jal  out 1  control strobes
//   aluc     out  4   ALU operation code
// ============================================================================
module id_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] inst,
  input  logic [31:0] pc4,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] wd,
  output logic [1:0]  pcsource,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] imm,
  output logic [4:0]  rn,
  output logic        wreg,
  output logic        m2reg,
  output logic        wmem,
  output logic        aluimm,
  output logic        shift,
  output logic        jal,
  output logic [3:0]  aluc
);

  // --------------------------------------------------------------------------
  // Register file. Entry 0 is not stored: it always reads zero.
  // --------------------------------------------------------------------------
  logic [31:0] r_regs [1:31];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (we && (wn != 5'd0)) begin
      r_regs[wn] <= wd;
    end
  end

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [31:0] w_qa;
  logic [31:0] w_qb;

  assign w_rs = inst[25:21];
  assign w_rt = inst[20:16];

  always_comb begin
    w_qa = 32'd0;
    w_qb = 32'd0;
    if (w_rs != 5'd0) begin
      w_qa = r_regs[w_rs];
`ifdef REGFILE_BYPASS_EN
      // Write-through; suppressed in reset so reads stay zero while clrn=0.
      if (clrn && we && (wn == w_rs)) w_qa = wd;
`endif
    end
    if (w_rt != 5'd0) begin
      w_qb = r_regs[w_rt];
`ifdef REGFILE_BYPASS_EN
      if (clrn && we && (wn == w_rt)) w_qb = wd;
`endif
    end
  end

  assign qa = w_qa;
  assign qb = w_qb;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_rtype;
  logic       w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr;
  logic       w_addi, w_andi, w_ori, w_xori, w_lw, w_sw, w_beq, w_bne;
  logic       w_lui, w_j, w_jal;
  logic       w_r_alu;
  logic       w_i_alu;
  logic       w_sext;
  logic       w_jump;
  logic       w_taken;

  assign w_op    = inst[31:26];
  assign w_fn    = inst[5:0];
  assign w_rtype = (w_op == 6'h00);

  assign w_add   = w_rtype && (w_fn == 6'h20);
  assign w_sub   = w_rtype && (w_fn == 6'h22);
  assign w_and   = w_rtype && (w_fn == 6'h24);
  assign w_or    = w_rtype && (w_fn == 6'h25);
  assign w_xor   = w_rtype && (w_fn == 6'h26);
  assign w_sll   = w_rtype && (w_fn == 6'h00);
  assign w_srl   = w_rtype && (w_fn == 6'h02);
  assign w_sra   = w_rtype && (w_fn == 6'h03);
  assign w_jr    = w_rtype && (w_fn == 6'h08);

  assign w_addi  = (w_op == 6'h08);
  assign w_andi  = (w_op == 6'h0c);
  assign w_ori   = (w_op == 6'h0d);
  assign w_xori  = (w_op == 6'h0e);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2b);
  assign w_beq   = (w_op == 6'h04);
  assign w_bne   = (w_op == 6'h05);
  assign w_lui   = (w_op == 6'h0f);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);

  assign w_r_alu = w_add | w_sub | w_and | w_or | w_xor | w_sll | w_srl | w_sra;
  assign w_i_alu = w_addi | w_andi | w_ori | w_xori;
  assign w_sext  = w_addi | w_lw | w_sw | w_beq | w_bne;
  assign w_jump  = w_j | w_jal | w_jr;
  assign w_taken = (w_beq && (w_qa == w_qb)) || (w_bne && (w_qa != w_qb));

  // Unrecognised encodings match none of the decode terms above, so every
  // strobe (including wreg/wmem) falls to zero and pcsource stays 00.
  assign wreg    = w_r_alu | w_i_alu | w_lw | w_lui | w_jal;
  assign m2reg   = w_lw;
  assign wmem    = w_sw;
  assign aluimm  = w_i_alu | w_lw | w_sw | w_lui;
  assign shift   = w_sll | w_srl | w_sra;
  assign jal     = w_jal;

  assign imm = w_sext ? {{16{inst[15]}}, inst[15:0]} : {16'd0, inst[15:0]};
  assign bpc = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
  assign jpc = w_jr ? w_qa : {pc4[31:28], inst[25:0], 2'b00};

  always_comb begin
    pcsource = 2'b00;
    if (w_jump) begin
      pcsource = 2'b10;
    end else if (w_taken) begin
      pcsource = 2'b01;
    end
  end

  always_comb begin
    rn = w_rt;
    if (w_r_alu) rn = inst[15:11];
    if (w_jal)   rn = 5'd31;
  end

  // Bit-sliced ALU code: add 0000, sub 0100, and 0001, or 0101, xor 0010,
  // lui 0110, sll 0011, srl 0111, sra 1111. Branches compare by subtract;
  // loads/stores use add (all-zero code).
  always_comb begin
    aluc    = 4'b0000;
    aluc[3] = w_sra;
    aluc[2] = w_sub | w_beq | w_bne | w_or | w_ori | w_lui | w_srl | w_sra;
    aluc[1] = w_xor | w_xori | w_lui | w_sll | w_srl | w_sra;
    aluc[0] = w_and | w_andi | w_or | w_ori | w_sll | w_srl | w_sra;
  end

endmodule
`default_nettype wire
